// File: rtl/io_pad_ctrl.sv
// Run-time pad direction/drive controller for a GPIO bank.
// Configuration arrives as 16-bit serial frames and is synchronised into wb_clk_i.
module io_pad_ctrl #(
  parameter int NUM_PADS    = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                i_reg_csb,
  input  logic                i_reg_sclk,
  input  logic                i_reg_mosi,
  input  logic                i_lock,
  input  logic [NUM_PADS-1:0] i_core_out,
  input  logic [NUM_PADS-1:0] i_core_oeb,
  output logic [NUM_PADS-1:0] io_out,
  output logic [NUM_PADS-1:0] io_oeb,
  output logic                o_frame_ok,
  output logic                o_frame_err,
  output logic [7:0]          o_frame_count
);

  localparam logic [7:0] PADS_B   = 8'(NUM_PADS);
  localparam logic [7:0] BCAST    = 8'hFF;
  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_SAT  = 5'd17;

  logic [SYNC_STAGES-1:0] r_csb_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_csb_prev;
  logic                   r_sclk_prev;

  logic                   w_csb;
  logic                   w_sclk;
  logic                   w_mosi;
  logic                   w_csb_fall;
  logic                   w_csb_rise;
  logic                   w_sclk_rise;

  logic [15:0]            r_shift;
  logic [4:0]             r_bit_cnt;
  logic                   r_frame_ok;
  logic                   r_frame_err;
  logic [7:0]             r_frame_count;

  logic [7:0]             w_addr;
  logic                   w_bcast;
  logic                   w_addr_ok;
  logic                   w_accept;
  logic                   w_reject;

  // csb idles high in the synchroniser so leaving reset never looks like a frame end.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_csb_sync  <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_csb_prev  <= 1'b1;
      r_sclk_prev <= 1'b0;
    end else begin
      r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], i_reg_csb};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_reg_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_reg_mosi};
      r_csb_prev  <= w_csb;
      r_sclk_prev <= w_sclk;
    end
  end

  assign w_csb       = r_csb_sync[SYNC_STAGES-1];
  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_csb_fall  = r_csb_prev & ~w_csb;
  assign w_csb_rise  = ~r_csb_prev & w_csb;
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;

  assign w_addr    = r_shift[15:8];
  assign w_bcast   = (w_addr == BCAST);
  assign w_addr_ok = (w_addr < PADS_B) | w_bcast;
  assign w_accept  = w_csb_rise & (r_bit_cnt == CNT_FULL) & ~i_lock & w_addr_ok;
  assign w_reject  = w_csb_rise & ~w_accept;

  // An sclk edge coincident with the csb rise sees w_csb high and is dropped.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_frame_ok    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_ok  <= w_accept;
      r_frame_err <= w_reject;
      if (w_csb_fall) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_sclk_rise && !w_csb) begin
        r_shift <= {r_shift[14:0], w_mosi};
        if (r_bit_cnt != CNT_SAT) begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
      end
      if (w_accept && (r_frame_count != 8'hFF)) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign o_frame_ok    = r_frame_ok;
  assign o_frame_err   = r_frame_err;
  assign o_frame_count = r_frame_count;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      localparam logic [7:0] PAD_IDX = 8'(gi);
      logic [1:0] r_mode;
      logic       r_const;
      logic       r_out;
      logic       r_oeb;
      logic       w_sel;

      assign w_sel = w_accept & (w_bcast | (w_addr == PAD_IDX));

      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          r_mode  <= 2'b00;
          r_const <= 1'b0;
        end else if (w_sel) begin
          r_mode  <= r_shift[1:0];
          r_const <= r_shift[2];
        end
      end

      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          r_out <= 1'b0;
          r_oeb <= 1'b1;
        end else begin
          case (r_mode)
            2'b00: begin
              r_out <= 1'b0;
              r_oeb <= 1'b1;
            end
            2'b01: begin
              r_out <= i_core_out[gi];
              r_oeb <= 1'b0;
            end
            2'b10: begin
              r_out <= i_core_out[gi];
              r_oeb <= i_core_oeb[gi];
            end
            default: begin
              r_out <= r_const;
              r_oeb <= 1'b0;
            end
          endcase
        end
      end

      assign io_out[gi] = r_out;
      assign io_oeb[gi] = r_oeb;
    end
  endgenerate

endmodule

// File: tb/tb_io_pad_ctrl.sv
// Directed bench for io_pad_ctrl: a per-pad configuration model drives a
// cycle-by-cycle comparison, backed by a few hand-computed literal checks.
module tb_io_pad_ctrl;
  localparam int NP = 6;
  localparam int PH = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          csb = 1'b1;
  logic          sclk = 1'b0;
  logic          mosi = 1'b0;
  logic          lock = 1'b0;
  logic [NP-1:0] core_out = '0;
  logic [NP-1:0] core_oeb = '0;
  logic [NP-1:0] io_out;
  logic [NP-1:0] io_oeb;
  logic          frame_ok;
  logic          frame_err;
  logic [7:0]    frame_count;

  io_pad_ctrl #(.NUM_PADS(NP), .SYNC_STAGES(2)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .i_reg_csb     (csb),
    .i_reg_sclk    (sclk),
    .i_reg_mosi    (mosi),
    .i_lock        (lock),
    .i_core_out    (core_out),
    .i_core_oeb    (core_oeb),
    .io_out        (io_out),
    .io_oeb        (io_oeb),
    .o_frame_ok    (frame_ok),
    .o_frame_err   (frame_err),
    .o_frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ok_seen  = 0;
  int err_seen = 0;
  bit chk_en   = 1'b0;

  int m_mode [NP];
  bit m_const[NP];
  int m_cnt;

  logic [NP-1:0] cq_out = '0;
  logic [NP-1:0] cq_oeb = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NP; n++) begin
      m_mode[n]  = 0;
      m_const[n] = 1'b0;
    end
    m_cnt = 0;
  endtask

  task automatic model_frame(input logic [15:0] f, input int nbits, input bit lk, output bit acc);
    int addr;
    addr = int'(f[15:8]);
    acc = 1'b0;
    if (nbits == 16 && !lk) begin
      if (addr < NP) begin
        m_mode[addr]  = int'(f[1:0]);
        m_const[addr] = f[2];
        acc = 1'b1;
      end else if (addr == 255) begin
        for (int n = 0; n < NP; n++) begin
          m_mode[n]  = int'(f[1:0]);
          m_const[n] = f[2];
        end
        acc = 1'b1;
      end
    end
    if (acc) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
  endtask

  // Core inputs as seen by the DUT at the most recent rising edge.
  always @(posedge clk) begin
    cq_out <= core_out;
    cq_oeb <= core_oeb;
  end

  always @(negedge clk) begin
    if (frame_ok === 1'b1) ok_seen++;
    if (frame_err === 1'b1) err_seen++;
  end

  always @(negedge clk) begin
    logic [NP-1:0] e_out;
    logic [NP-1:0] e_oeb;
    if (chk_en) begin
      for (int n = 0; n < NP; n++) begin
        case (m_mode[n])
          0:       begin e_oeb[n] = 1'b1;      e_out[n] = 1'b0;       end
          1:       begin e_oeb[n] = 1'b0;      e_out[n] = cq_out[n];  end
          2:       begin e_oeb[n] = cq_oeb[n]; e_out[n] = cq_out[n];  end
          default: begin e_oeb[n] = 1'b0;      e_out[n] = m_const[n]; end
        endcase
      end
      check("io_out", 32'(io_out), 32'(e_out));
      check("io_oeb", 32'(io_oeb), 32'(e_oeb));
      check("frame_count", 32'(frame_count), 32'(m_cnt));
      check("idle_pulses", {30'd0, frame_ok, frame_err}, 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    csb = 1'b0;
    tick(PH);
  endtask

  task automatic send_bits(input logic [31:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = v[i];
      tick(PH);
      sclk = 1'b1;
      tick(PH);
      sclk = 1'b0;
    end
  endtask

  task automatic end_frame(input logic [15:0] f, input int nbits);
    int ok0;
    int err0;
    bit acc;
    tick(PH);
    chk_en = 1'b0;
    ok0  = ok_seen;
    err0 = err_seen;
    csb  = 1'b1;
    tick(10);
    model_frame(f, nbits, lock, acc);
    check("ok_pulses", 32'(ok_seen - ok0), acc ? 32'd1 : 32'd0);
    check("err_pulses", 32'(err_seen - err0), acc ? 32'd0 : 32'd1);
    chk_en = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] v, input int nbits);
    start_frame();
    send_bits(v, nbits);
    end_frame(v[15:0], nbits);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    tick(3);
    rst = 1'b0;
    chk_en = 1'b1;
    tick(10);
    check("reset_oeb", 32'(io_oeb), 32'h3F);
    check("reset_out", 32'(io_out), 32'h0);
    check("reset_count", 32'(frame_count), 32'd0);

    send_frame(32'h0203, 16);
    check("pad2_const0_oeb", 32'(io_oeb), 32'h3B);
    check("pad2_const0_out", 32'(io_out), 32'h00);
    send_frame(32'h0207, 16);
    check("pad2_const1_out", 32'(io_out), 32'h04);
    check("count_two", 32'(frame_count), 32'd2);

    send_frame(32'hFF02, 16);
    core_oeb = 6'b101010;
    core_out = 6'b110011;
    @(negedge clk);
    check("core_oeb_old", 32'(io_oeb), 32'h00);
    check("core_out_old", 32'(io_out), 32'h00);
    @(negedge clk);
    check("core_oeb_new", 32'(io_oeb), 32'h2A);
    check("core_out_new", 32'(io_out), 32'h33);
    tick(2);

    send_frame(32'h0207, 15);
    send_frame(32'h10207, 17);
    send_frame(32'h0603, 16);
    lock = 1'b1;
    send_frame(32'h0003, 16);
    lock = 1'b0;
    check("count_after_rejects", 32'(frame_count), 32'd3);
    check("oeb_after_rejects", 32'(io_oeb), 32'h2A);

    start_frame();
    send_bits(32'h02, 8);
    chk_en = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    model_reset();
    tick(8);
    chk_en = 1'b1;
    send_bits(32'h07, 8);
    end_frame(16'h0207, 8);
    check("midreset_oeb", 32'(io_oeb), 32'h3F);
    check("midreset_count", 32'(frame_count), 32'd0);

    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = {16'd0, 8'(i % NP), 5'd0, 1'((i >> 3) & 1), 2'(i % 4)};
      send_frame(v, 16);
    end
    check("count_saturated", 32'(frame_count), 32'd255);
    tick(20);
    check("count_holds", 32'(frame_count), 32'd255);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_pad_ctrl.md
# io_pad_ctrl

Parametrised pad-direction/drive controller for the user-area GPIO bank, replacing the fixed tie-off controller that held a group of pads permanently high-Z for analog use. Each of NUM_PADS pads is configured at run time into analog (high-Z), core-output, core-controlled or constant-drive mode. Configuration arrives as 16-bit serial frames on three logic-analyser lines (csb/sclk/mosi) and is sampled in the wb_clk_i domain. Sits between the core blocks and the io_out/io_oeb pad slices in user_project_wrapper.

## Interface
- NUM_PADS, 6, number of controlled pads (1..254)
- SYNC_STAGES, 2, synchroniser flops on each serial input (≥2)
- wb_clk_i  input  1  system clock
- wb_rst_i  input  1  synchronous, active-high reset
- i_reg_csb  input  1  frame select, active low, asynchronous to wb_clk_i
- i_reg_sclk  input  1  serial clock, mosi sampled on rising edge
- i_reg_mosi  input  1  serial data, MSB first
- i_lock  input  1  when high, completed frames are not applied
- i_core_out  input  NUM_PADS  core output value per pad
- i_core_oeb  input  NUM_PADS  core output-enable-bar per pad
- io_out  output  NUM_PADS  pad output value
- io_oeb  output  NUM_PADS  pad output-enable-bar (1 = high-Z)
- o_frame_ok  output  1  one-cycle pulse: frame applied
- o_frame_err  output  1  one-cycle pulse: frame rejected
- o_frame_count  output  8  applied-frame counter, saturates at 255

## Operation
- Inputs csb/sclk/mosi each pass through SYNC_STAGES flops, then one edge-detect flop; all logic uses synchronised copies.
- Frame = 16 bits: [15:8] addr, [7:3] reserved (ignored), [2] const, [1:0] mode.
- Sync csb falling edge: clear shift register and 5-bit bit counter (saturates at 17).
- Sync sclk rising edge while sync csb low: shift mosi into LSB, increment counter. sclk edges while csb high ignored.
- Sync csb rising edge: evaluate frame.
  - count ≠ 16 → reject.
  - i_lock high → reject.
  - addr < NUM_PADS → write mode/const of pad addr; accept.
  - addr = 0xFF → write all pads (broadcast); accept.
  - otherwise → reject.
- Accept: o_frame_ok pulse, o_frame_count +1 (hold at 255). Reject: o_frame_err pulse, no config change.
- Per-pad mode → registered outputs:
  - 00 analog: oeb=1, out=0.
  - 01 core output: oeb=0, out=i_core_out[n].
  - 10 core controlled: oeb=i_core_oeb[n], out=i_core_out[n].
  - 11 constant: oeb=0, out=const[n].
- Reset: all pads mode 00, const 0; io_oeb all 1, io_out all 0; o_frame_ok=0, o_frame_err=0, o_frame_count=0; shift register and counter cleared. Reset mid-frame discards the frame; the frame in progress is not applied even if csb later rises (counter was cleared, so count ≠ 16 unless a fresh frame follows csb fall).

## Timing
- Serial-input-to-event latency: SYNC_STAGES+1 cycles.
- sclk high and low phases, csb setup/hold around sclk edges: each ≥ SYNC_STAGES+2 wb_clk_i cycles; faster sclk is unsupported.
- Config registers update the cycle after the synced csb-rise is detected; o_frame_ok/o_frame_err asserted in that same cycle for exactly one cycle.
- io_out/io_oeb are registered: one cycle after config update, and one cycle after any i_core_out/i_core_oeb change in modes 01/10.
- csb rise and sclk rise detected in the same cycle: the sclk edge is not shifted (csb high wins).
- csb low→high→low with no sclk: count 0 → reject.
- i_lock sampled in the evaluation cycle only.
- o_frame_count at 255: accepted frames still pulse o_frame_ok, count holds.

## Test plan
- Reset, then check for 10 cycles → io_oeb=6'b111111, io_out=0, count=0, no pulses.
- Frame 0x0203 (pad 2, mode 11, const 0) then 0x0207 → pad 2 oeb=0, out=0 then out=1; o_frame_ok twice, count=2; other pads unchanged.
- Broadcast 0xFF02, drive i_core_oeb=6'b101010, i_core_out=6'b110011 → io_oeb=101010, io_out=110011, both one cycle after input change.
- Reject cases: 15-bit frame, 17-bit frame, addr 0x06, valid frame with i_lock=1 → four o_frame_err pulses, outputs and count unchanged.
- Assert wb_rst_i after bit 8 of a frame, release, then complete the remaining 8 bits and raise csb → frame rejected; all pads back to analog mode.
- 256 accepted frames → o_frame_count=255 and holds; 256th frame still pulses o_frame_ok.
